// File: rtl/pipeline_acc_mc_pkg.sv
// Shared width helpers for the multi-channel pipelined accumulator.
package pipeline_acc_mc_pkg;

   // Round a width up to the next even number so the accumulator splits into two equal halves.
   function automatic int even_up(input int w);
      return w + (w % 2);
   endfunction

   // Accumulator width: result width plus guard bits, rounded up to even.
   function automatic int calc_aw(input int out_w, input int guard_w);
      return even_up(out_w + guard_w);
   endfunction

   // Split point of the two-half adder.
   function automatic int calc_h(input int aw);
      return aw / 2;
   endfunction

endpackage

// File: rtl/pipeline_acc_mc_if.sv
// Operand stream in, result vector out, for pipeline_acc_mc.
interface pipeline_acc_mc_if #(
   parameter int C_IN  = 12,
   parameter int C_OUT = 20,
   parameter int C_CH  = 4
) ();
   logic [C_CH*C_IN-1:0]  I_operand;
   logic                  I_op_rdy;
   logic                  I_op_last;
   logic                  O_result_rdy;
   logic [C_CH*C_OUT-1:0] O_result;
   logic [C_CH-1:0]       O_ovf;

   // Producer side: drives operands, observes results.
   modport master (
      output I_operand, I_op_rdy, I_op_last,
      input  O_result_rdy, O_result, O_ovf
   );

   // Accumulator side.
   modport slave (
      input  I_operand, I_op_rdy, I_op_last,
      output O_result_rdy, O_result, O_ovf
   );
endinterface

// File: rtl/pipeline_acc_lane.sv
// One channel of the accumulator datapath: split-carry add, group snapshot,
// overflow detection and saturate/wrap output. Control comes from the top.
module pipeline_acc_lane
   import pipeline_acc_mc_pkg::*;
#(
   parameter int C_IN  = 12,
   parameter int C_OUT = 20,
   parameter int C_AW  = 24,
   parameter int C_SAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [C_IN-1:0]  operand,
   input  logic             beat_en,
   input  logic             fresh,
   input  logic             v_1d,
   input  logic             fresh_1d,
   input  logic             last_1d,
   input  logic             last_2d,
   input  logic             last_3d,
   output logic [C_OUT-1:0] result,
   output logic             ovf
);
   localparam int C_H = calc_h(C_AW);
   localparam logic [C_OUT-1:0] SAT_MAX = {1'b0, {(C_OUT-1){1'b1}}};
   localparam logic [C_OUT-1:0] SAT_MIN = {1'b1, {(C_OUT-1){1'b0}}};

   logic [C_AW-1:0]      op_ext;
   logic [C_H-1:0]       lo_base;
   logic [C_H:0]         lo_sum;
   logic [C_H-1:0]       hi_base;
   logic [C_H-1:0]       hi_sum;
   logic [C_AW-C_OUT:0]  ext_bits;

   logic [C_H-1:0]   acc_lo_q,   acc_lo_d;
   logic             carry_1d_q, carry_1d_d;
   logic [C_H-1:0]   op_hi_1d_q, op_hi_1d_d;
   logic [C_H-1:0]   acc_hi_q,   acc_hi_d;
   logic [C_AW-1:0]  sum_2d_q,   sum_2d_d;
   logic [C_OUT-1:0] low_3d_q,   low_3d_d;
   logic             ovf_3d_q,   ovf_3d_d;
   logic             neg_3d_q,   neg_3d_d;
   logic [C_OUT-1:0] result_q,   result_d;
   logic             ovf_q,      ovf_d;

   // Next-state for all three stages; every stage holds unless its enable is set.
   always_comb begin
      acc_lo_d   = acc_lo_q;
      carry_1d_d = carry_1d_q;
      op_hi_1d_d = op_hi_1d_q;
      acc_hi_d   = acc_hi_q;
      sum_2d_d   = sum_2d_q;
      low_3d_d   = low_3d_q;
      ovf_3d_d   = ovf_3d_q;
      neg_3d_d   = neg_3d_q;
      result_d   = result_q;
      ovf_d      = ovf_q;

      // Stage 1: low half; carry is parked for the high half next cycle.
      op_ext  = {{(C_AW-C_IN){operand[C_IN-1]}}, operand};
      lo_base = fresh ? '0 : acc_lo_q;
      lo_sum  = {1'b0, lo_base} + {1'b0, op_ext[C_H-1:0]};
      if (beat_en) begin
         acc_lo_d   = lo_sum[C_H-1:0];
         carry_1d_d = lo_sum[C_H];
         op_hi_1d_d = op_ext[C_AW-1:C_H];
      end

      // Stage 2: high half; snapshot on the closing beat so the next group can start at once.
      hi_base = fresh_1d ? '0 : acc_hi_q;
      hi_sum  = hi_base + op_hi_1d_q + {{(C_H-1){1'b0}}, carry_1d_q};
      if (v_1d) begin
         acc_hi_d = hi_sum;
      end
      if (last_1d) begin
         sum_2d_d = {hi_sum, acc_lo_q};
      end

      // Stage 3a: the sum fits in C_OUT only if all bits above the result sign agree with it.
      ext_bits = sum_2d_q[C_AW-1:C_OUT-1];
      if (last_2d) begin
         low_3d_d = sum_2d_q[C_OUT-1:0];
         ovf_3d_d = (|ext_bits) && !(&ext_bits);
         neg_3d_d = sum_2d_q[C_AW-1];
      end

      // Stage 3b: pick clipped or wrapped value; held until the next group closes.
      if (last_3d) begin
         ovf_d = ovf_3d_q;
         if ((C_SAT != 0) && ovf_3d_q) begin
            result_d = neg_3d_q ? SAT_MIN : SAT_MAX;
         end else begin
            result_d = low_3d_q;
         end
      end
   end

   // Lane state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_lo_q   <= '0;
         carry_1d_q <= 1'b0;
         op_hi_1d_q <= '0;
         acc_hi_q   <= '0;
         sum_2d_q   <= '0;
         low_3d_q   <= '0;
         ovf_3d_q   <= 1'b0;
         neg_3d_q   <= 1'b0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         acc_lo_q   <= acc_lo_d;
         carry_1d_q <= carry_1d_d;
         op_hi_1d_q <= op_hi_1d_d;
         acc_hi_q   <= acc_hi_d;
         sum_2d_q   <= sum_2d_d;
         low_3d_q   <= low_3d_d;
         ovf_3d_q   <= ovf_3d_d;
         neg_3d_q   <= neg_3d_d;
         result_q   <= result_d;
         ovf_q      <= ovf_d;
      end
   end

   assign result = result_q;
   assign ovf    = ovf_q;
endmodule

// File: rtl/pipeline_acc_mc.sv
// Multi-channel pipelined signed accumulator: shared control, C_CH datapath lanes.
module pipeline_acc_mc
   import pipeline_acc_mc_pkg::*;
#(
   parameter int C_IN    = 12,
   parameter int C_OUT   = 20,
   parameter int C_CH    = 4,
   parameter int C_GUARD = 4,
   parameter int C_SAT   = 1
) (
   input logic              I_clk,
   input logic              I_rst_n,
   pipeline_acc_mc_if.slave bus
);
   localparam int C_AW = calc_aw(C_OUT, C_GUARD);

   logic fresh_q,    fresh_d;
   logic v_1d_q,     v_1d_d;
   logic fresh_1d_q, fresh_1d_d;
   logic last_1d_q,  last_1d_d;
   logic last_2d_q,  last_2d_d;
   logic last_3d_q,  last_3d_d;
   logic rdy_q,      rdy_d;

   logic [C_CH*C_OUT-1:0] result_all;
   logic [C_CH-1:0]       ovf_all;

   // Control pipeline: fresh re-arms on every accepted last; lasts walk down to the output pulse.
   always_comb begin
      fresh_d    = fresh_q;
      if (bus.I_op_rdy) begin
         fresh_d = bus.I_op_last;
      end
      v_1d_d     = bus.I_op_rdy;
      fresh_1d_d = fresh_q;
      last_1d_d  = bus.I_op_rdy & bus.I_op_last;
      last_2d_d  = last_1d_q;
      last_3d_d  = last_2d_q;
      rdy_d      = last_3d_q;
   end

   // Control registers; reset discards anything in flight.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         fresh_q    <= 1'b1;
         v_1d_q     <= 1'b0;
         fresh_1d_q <= 1'b0;
         last_1d_q  <= 1'b0;
         last_2d_q  <= 1'b0;
         last_3d_q  <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         fresh_q    <= fresh_d;
         v_1d_q     <= v_1d_d;
         fresh_1d_q <= fresh_1d_d;
         last_1d_q  <= last_1d_d;
         last_2d_q  <= last_2d_d;
         last_3d_q  <= last_3d_d;
         rdy_q      <= rdy_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < C_CH; gi++) begin : g_lane
         pipeline_acc_lane #(
            .C_IN  (C_IN),
            .C_OUT (C_OUT),
            .C_AW  (C_AW),
            .C_SAT (C_SAT)
         ) u_lane (
            .clk      (I_clk),
            .rst_n    (I_rst_n),
            .operand  (bus.I_operand[gi*C_IN +: C_IN]),
            .beat_en  (bus.I_op_rdy),
            .fresh    (fresh_q),
            .v_1d     (v_1d_q),
            .fresh_1d (fresh_1d_q),
            .last_1d  (last_1d_q),
            .last_2d  (last_2d_q),
            .last_3d  (last_3d_q),
            .result   (result_all[gi*C_OUT +: C_OUT]),
            .ovf      (ovf_all[gi])
         );
      end
   endgenerate

   assign bus.O_result_rdy = rdy_q;
   assign bus.O_result     = result_all;
   assign bus.O_ovf        = ovf_all;
endmodule

// File: doc/pipeline_acc_mc.md
# pipeline_acc_mc

Multi-channel, pipelined, signed accumulator for the cnna datapath. It sums a stream of C_CH packed operands per beat into per-channel running totals, using a split-carry two-half adder so that one operand per cycle is accepted with no stall. On the last operand of a group it emits one result vector, saturated or wrapped to C_OUT bits, with per-channel overflow flags. It is the successor to the single-channel 2-stage pipelined adder/accumulator and sits after the multiplier array, ahead of the obuf write path.

## Interface
- C_IN, 12: operand width per channel, signed two's complement.
- C_OUT, 20: result width per channel, signed.
- C_CH, 4: number of independent channels.
- C_GUARD, 4: internal guard bits; accumulator width C_AW = C_OUT + C_GUARD, rounded up to even. Split point C_H = C_AW/2.
- C_SAT, 1: 1 = saturate the output to the C_OUT signed range; 0 = truncate to the low C_OUT bits.

- I_clk, in, 1: the single clock.
- I_rst_n, in, 1: asynchronous active-low reset.
- I_operand, in, C_CH*C_IN: channel k is at [k*C_IN +: C_IN].
- I_op_rdy, in, 1: operand valid for this cycle.
- I_op_last, in, 1: the qualified operand closes the group. Ignored when I_op_rdy=0.
- O_result_rdy, out, 1: one-cycle pulse per closed group.
- O_result, out, C_CH*C_OUT: channel k is at [k*C_OUT +: C_OUT]. Valid only while O_result_rdy=1.
- O_ovf, out, C_CH: per-channel flag, set when the C_AW sum did not fit in C_OUT (clipped or truncated). Valid with O_result_rdy.

## Operation
- Operands are sign-extended to C_AW.
- A fresh flag is set by reset and by every accepted last. When fresh=1, the next accepted operand loads the accumulator instead of adding to it.
- Stage 1 (low half), per channel:
  - On an accepted beat: {carry_1d, acc_lo} <= (fresh ? 0 : acc_lo) + op[C_H-1:0].
  - op_hi_1d <= op[C_AW-1:C_H]. A flag v_1d records valid, last and fresh.
- Stage 2 (high half):
  - When v_1d=1: acc_hi <= (fresh_1d ? 0 : acc_hi) + op_hi_1d + carry_1d, modulo 2^C_H.
  - When last_1d=1, also snapshot sum_2d <= {new acc_hi, acc_lo}.
  - The snapshot isolates the result from a new group starting one cycle later.
- Stage 3 (output):
  - C_SAT=1: clip sum_2d to [-2^(C_OUT-1), 2^(C_OUT-1)-1].
  - C_SAT=0: take sum_2d[C_OUT-1:0].
  - O_ovf = (sum_2d differs from the sign-extension of its low C_OUT bits).
- Idle cycles (I_op_rdy=0) hold all accumulator state.
- A group of one operand (rdy&last on the first beat) returns that operand.
- Overflow of C_AW itself wraps silently. Sizing C_GUARD for the group length is the user's responsibility.
- Channels share the control path and differ only in data.

## Timing
- Reset values: O_result_rdy=0, O_result=0, O_ovf=0, all accumulators 0, fresh=1, pipeline valids 0.
- Latency: I_op_rdy&I_op_last sampled at edge t produces O_result_rdy=1 in the cycle after edge t+3, for exactly one cycle. O_result and O_ovf hold their value until the next pulse.
- Throughput: one operand per cycle, with no back-pressure.
- Consecutive lasts on edges t and t+1 give pulses on consecutive cycles with independent sums.
- Reset asserted mid-group discards partial sums and any in-flight result; no pulse follows reset.
- Critical path is one C_H-bit adder plus a mux.

## Structure
- Shared cnna header/package: an even-rounding width function, and the C_AW and C_H derivations.
- One sub-module: pipeline_acc_lane, covering a single channel's stages 1–3 (data path only). It is instantiated C_CH times by generate.
- Control (fresh, v_1d, last_1d, last_2d) lives once in the top.

## Test plan
Defaults for all scenarios: C_IN=12, C_OUT=20, C_GUARD=4, C_CH=4, C_SAT=1 unless stated.

- Reset: hold I_rst_n=0 with random I_operand and I_op_rdy=1 → O_result_rdy=0, O_result=0, O_ovf=0 throughout.
- Basic: ch0 gets 100, 200, -50 (last); other channels get 1, 1, 1 → O_result_rdy pulse 3 cycles after the last; ch0=250, ch1..3=3, O_ovf=0.
- Carry across halves with gaps: ch0 gets 2047 ×3 with I_op_rdy=0 gaps between beats → 6141 (low-half carry exercised), with the pulse timed from the last beat.
- Saturation: 300 × 2047 → 524287, O_ovf[0]=1. 300 × -2048 → -524288, O_ovf=1. With C_SAT=0, 300 × 2047 → -434476, O_ovf=1.
- Back-to-back groups: {7, 8 last} then {-3 last} on the very next cycle, then {5 last} → pulses on 3 consecutive cycles carrying 15, -3, 5.
- Reset mid-group: accept 10 and 20, pulse I_rst_n low for one cycle, then send 5 (last) → single pulse with result 5; no pulse for the discarded group.
